// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master arbiter for a single-port synchronous-read data
//               memory, with lock support and tagged one-cycle read return.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wen,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_OPEN = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic c_FIXED = (FIXED_PRIO != 0);

    state_t          r_state;
    logic            r_last_gnt;
    logic            r_rd_pend;
    logic            r_rd_tag;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_acc;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic            w_rv0;
    logic            w_rv1;

    // r_last_gnt=1 means master 1 was granted last, so master 0 wins the next tie.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_OWN0: w_gnt0 = m0_req;
                ST_OWN1: w_gnt1 = m1_req;
                default: begin
                    if (m0_req && m1_req) begin
                        if (c_FIXED || r_last_gnt) begin
                            w_gnt0 = 1'b1;
                        end else begin
                            w_gnt1 = 1'b1;
                        end
                    end else begin
                        w_gnt0 = m0_req;
                        w_gnt1 = m1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_acc   = w_gnt0 | w_gnt1;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (w_gnt0) begin
            w_we    = m0_we;
            w_addr  = m0_addr;
            w_wdata = m0_wdata;
        end else if (w_gnt1) begin
            w_we    = m1_we;
            w_addr  = m1_addr;
            w_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_OPEN;
            r_last_gnt <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_rd_tag   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_rd_pend <= w_acc & ~w_we;
            if (w_acc) begin
                r_addr     <= w_addr;
                r_wdata    <= w_wdata;
                r_last_gnt <= w_gnt1;
                r_rd_tag   <= w_gnt1;
            end
            case (r_state)
                ST_OPEN: begin
                    if (w_gnt0 && m0_lock) begin
                        r_state <= ST_OWN0;
                    end else if (w_gnt1 && m1_lock) begin
                        r_state <= ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    if ((w_gnt0 && !m0_lock) || (!m0_req && !m0_lock)) begin
                        r_state <= ST_OPEN;
                    end
                end
                ST_OWN1: begin
                    if ((w_gnt1 && !m1_lock) || (!m1_req && !m1_lock)) begin
                        r_state <= ST_OPEN;
                    end
                end
                default: r_state <= ST_OPEN;
            endcase
        end
    end

    // Gating with reset drops a read whose data would land in a reset cycle.
    assign w_rv0 = r_rd_pend & ~r_rd_tag & ~reset;
    assign w_rv1 = r_rd_pend &  r_rd_tag & ~reset;

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = w_rv0;
    assign m1_rvalid = w_rv1;
    assign m0_rdata  = w_rv0 ? mem_rdata : '0;
    assign m1_rdata  = w_rv1 ? mem_rdata : '0;

    assign mem_addr  = w_addr;
    assign mem_wdata = w_wdata;
    assign mem_wen   = w_acc & w_we;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed bench for dmem_arbiter, round-robin and fixed-priority
//               instances, each backed by a small synchronous-read memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_mem_wen;
    logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid, fp_mem_wen;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;
    logic [31:0] mem_a [0:63] = '{default: '0};
    logic [31:0] mem_b [0:63] = '{default: '0};

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata),
        .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_wen(rr_mem_wen),
        .mem_rdata(rr_mem_rdata)
    );

    dmem_arbiter #(.AW(32), .DW(32), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wen(fp_mem_wen),
        .mem_rdata(fp_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) mem_a[pl_idx] <= pl_data;
        else if (rr_mem_wen) mem_a[rr_mem_addr[7:2]] <= rr_mem_wdata;
        rr_mem_rdata <= mem_a[rr_mem_addr[7:2]];
    end

    always @(posedge clk) begin
        if (pl_en) mem_b[pl_idx] <= pl_data;
        else if (fp_mem_wen) mem_b[fp_mem_addr[7:2]] <= fp_mem_wdata;
        fp_mem_rdata <= mem_b[fp_mem_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_lock = 0; m1_req = 0; m1_we = 0; m1_lock = 0;
    endtask

    task automatic do_reset();
        cyc();
        idle_all();
        reset = 1;
        cyc();
        reset = 0;
    endtask

    initial begin
        reset = 1; idle_all();
        m0_addr = 0; m0_wdata = 0; m1_addr = 0; m1_wdata = 0;
        pl_en = 1; pl_idx = 6'd4; pl_data = 32'hDEADBEEF;
        cyc();
        pl_idx = 6'd5; pl_data = 32'h11111111;
        m0_req = 1; m0_we = 1; m1_req = 1;
        #3;
        chk("rst_m0_gnt", {31'd0, rr_m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'd0, rr_m1_gnt}, 32'd0);
        chk("rst_wen", {31'd0, rr_mem_wen}, 32'd0);
        chk("rst_fp_gnt", {31'd0, fp_m0_gnt}, 32'd0);
        cyc();
        pl_en = 0; reset = 0; idle_all();
        #3;
        chk("rst_addr", rr_mem_addr, 32'd0);
        chk("rst_wdata", rr_mem_wdata, 32'd0);
        chk("rst_m0_rvalid", {31'd0, rr_m0_rvalid}, 32'd0);
        chk("rst_m1_rvalid", {31'd0, rr_m1_rvalid}, 32'd0);

        // single read
        cyc();
        m0_req = 1; m0_addr = 32'h10;
        #3;
        chk("rd_m0_gnt", {31'd0, rr_m0_gnt}, 32'd1);
        chk("rd_m1_gnt", {31'd0, rr_m1_gnt}, 32'd0);
        chk("rd_wen", {31'd0, rr_mem_wen}, 32'd0);
        chk("rd_addr", rr_mem_addr, 32'h10);
        cyc();
        m0_req = 0;
        #3;
        chk("rd_m0_rvalid", {31'd0, rr_m0_rvalid}, 32'd1);
        chk("rd_m0_rdata", rr_m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", {31'd0, rr_m1_rvalid}, 32'd0);
        chk("rd_m1_rdata", rr_m1_rdata, 32'd0);
        chk("rd_addr_hold", rr_mem_addr, 32'h10);

        // round-robin conflict
        do_reset();
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h14;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin m0_req = 0; m1_req = 0; end
            #3;
            if (i < 4) begin
                chk($sformatf("rr_m0_gnt%0d", i), {31'd0, rr_m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("rr_m1_gnt%0d", i), {31'd0, rr_m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (i > 0) begin
                chk($sformatf("rr_m0_rv%0d", i), {31'd0, rr_m0_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("rr_m1_rv%0d", i), {31'd0, rr_m1_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("rr_m0_rd%0d", i), rr_m0_rdata, (i % 2 == 1) ? 32'hDEADBEEF : 32'd0);
                chk($sformatf("rr_m1_rd%0d", i), rr_m1_rdata, (i % 2 == 0) ? 32'h11111111 : 32'd0);
            end
            cyc();
        end

        // fixed priority
        do_reset();
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h14;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("fp_m0_gnt%0d", i), {31'd0, fp_m0_gnt}, 32'd1);
            chk($sformatf("fp_m1_gnt%0d", i), {31'd0, fp_m1_gnt}, 32'd0);
            cyc();
        end
        m0_req = 0;
        #3;
        chk("fp_m1_gnt_free", {31'd0, fp_m1_gnt}, 32'd1);
        chk("fp_m0_gnt_free", {31'd0, fp_m0_gnt}, 32'd0);
        cyc();
        m1_req = 0;

        // write then read
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_wdata = 32'h55AA;
        #3;
        chk("wr_gnt", {31'd0, rr_m1_gnt}, 32'd1);
        chk("wr_wen", {31'd0, rr_mem_wen}, 32'd1);
        chk("wr_wdata", rr_mem_wdata, 32'h55AA);
        chk("wr_addr", rr_mem_addr, 32'h8);
        cyc();
        m1_we = 0;
        #3;
        chk("wrrd_wen", {31'd0, rr_mem_wen}, 32'd0);
        chk("wrrd_gnt", {31'd0, rr_m1_gnt}, 32'd1);
        chk("wr_no_rvalid", {31'd0, rr_m1_rvalid}, 32'd0);
        cyc();
        m1_req = 0;
        #3;
        chk("wrrd_rvalid", {31'd0, rr_m1_rvalid}, 32'd1);
        chk("wrrd_rdata", rr_m1_rdata, 32'h55AA);
        chk("wrrd_wen_idle", {31'd0, rr_mem_wen}, 32'd0);

        // lock
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 32'h20;
        #3;
        chk("lk_rd_gnt", {31'd0, rr_m0_gnt}, 32'd1);
        cyc();
        m0_req = 0; m1_req = 1; m1_addr = 32'h14;
        #3;
        chk("lk_hold_m1_gnt", {31'd0, rr_m1_gnt}, 32'd0);
        chk("lk_rd_rvalid", {31'd0, rr_m0_rvalid}, 32'd1);
        cyc();
        m0_req = 1; m0_we = 1; m0_lock = 0; m0_wdata = 32'hCAFE;
        #3;
        chk("lk_wr_gnt", {31'd0, rr_m0_gnt}, 32'd1);
        chk("lk_wr_m1_gnt", {31'd0, rr_m1_gnt}, 32'd0);
        chk("lk_wr_wen", {31'd0, rr_mem_wen}, 32'd1);
        cyc();
        m0_req = 0; m0_we = 0;
        #3;
        chk("lk_rel_m1_gnt", {31'd0, rr_m1_gnt}, 32'd1);
        chk("lk_rel_addr", rr_mem_addr, 32'h14);
        cyc();
        m1_req = 0;

        // reset with a read in flight
        m0_req = 1; m0_addr = 32'h10;
        #3;
        chk("rm_gnt", {31'd0, rr_m0_gnt}, 32'd1);
        cyc();
        m0_req = 0; reset = 1;
        #3;
        chk("rm_rvalid_rst", {31'd0, rr_m0_rvalid}, 32'd0);
        cyc();
        reset = 0; m0_req = 1; m1_req = 1;
        #3;
        chk("rm_rvalid_after", {31'd0, rr_m0_rvalid}, 32'd0);
        chk("rm_m1_rvalid", {31'd0, rr_m1_rvalid}, 32'd0);
        chk("rm_first_m0", {31'd0, rr_m0_gnt}, 32'd1);
        chk("rm_first_m1", {31'd0, rr_m1_gnt}, 32'd0);
        cyc();
        idle_all();
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
